// File: rtl/apix_pkg.sv
// Shared constants and types for the APIX serial link.
// Used by both the transmitter and the receiver.
package apix_pkg;

    localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
    localparam logic [7:0] CRC_POLY      = 8'h07;
    localparam logic [7:0] CRC_INIT      = 8'h00;
    localparam int         FRAME_BITS    = 40;
    localparam int         SYNC_BITS     = 8;
    localparam int         CRC_BITS      = 8;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_DATA,
        ST_CRC
    } rx_state_t;

    // One MSB-first step of the CRC-8 LFSR.
    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic       din
    );
        logic w_fb;
        w_fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/apix_crc8_serial.sv
// Bit-serial CRC-8 generator, one bit per enabled clock.
// Shared by the APIX transmitter and receiver.
module apix_crc8_serial
    import apix_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_crc
);

    logic [7:0] r_crc;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= crc8_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/apix_receiver.sv
// APIX serial receiver: sync hunt, pixel deserialiser, CRC-8 check,
// link lock tracking and saturating error statistics.
module apix_receiver
    import apix_pkg::*;
#(
    parameter int         PIXEL_W     = 24,
    parameter logic [7:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter int         LOCK_FRAMES = 4,
    parameter int         UNLOCK_ERRS = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_apix_data,
    output logic [PIXEL_W-1:0] o_pixel_data,
    output logic               o_pixel_valid,
    output logic               o_crc_error,
    output logic               o_locked,
    output logic [15:0]        o_err_count
);

    localparam int CNT_W = $clog2(PIXEL_W + 1);
    localparam int RUN_W = 8;

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PIXEL_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_BITS - 1);
    localparam logic [RUN_W-1:0] LOCK_N    = RUN_W'(LOCK_FRAMES);
    localparam logic [RUN_W-1:0] UNLOCK_N  = RUN_W'(UNLOCK_ERRS);

    rx_state_t          r_state;
    logic [6:0]         r_sync;
    logic [6:0]         r_rx_crc;
    logic [PIXEL_W-1:0] r_pix_sh;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [RUN_W-1:0]   r_good_run;
    logic [RUN_W-1:0]   r_bad_run;
    logic [PIXEL_W-1:0] r_pixel_data;
    logic               r_pixel_valid;
    logic               r_crc_error;
    logic               r_locked;
    logic [15:0]        r_err_count;

    logic [7:0]         w_sync_next;
    logic [7:0]         w_rx_crc_next;
    logic               w_sync_hit;
    logic               w_crc_en;
    logic [7:0]         w_crc;
    logic [RUN_W-1:0]   w_good_inc;
    logic [RUN_W-1:0]   w_bad_inc;
    logic [15:0]        w_err_inc;

    assign w_sync_next   = {r_sync, i_apix_data};
    assign w_rx_crc_next = {r_rx_crc, i_apix_data};
    assign w_sync_hit    = (r_state == ST_HUNT) && (w_sync_next == SYNC_WORD);
    assign w_crc_en      = (r_state == ST_DATA);

    assign w_good_inc = (r_good_run == LOCK_N) ? r_good_run
                                               : r_good_run + 1'b1;
    assign w_bad_inc  = (r_bad_run == UNLOCK_N) ? r_bad_run
                                                : r_bad_run + 1'b1;
    assign w_err_inc  = (r_err_count == 16'hFFFF) ? r_err_count
                                                  : r_err_count + 16'd1;

    apix_crc8_serial u_crc (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_sync_hit),
        .i_en    (w_crc_en),
        .i_bit   (i_apix_data),
        .o_crc   (w_crc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_HUNT;
            r_sync        <= '0;
            r_rx_crc      <= '0;
            r_pix_sh      <= '0;
            r_bit_cnt     <= '0;
            r_good_run    <= '0;
            r_bad_run     <= '0;
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
            r_crc_error   <= 1'b0;
            r_locked      <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_crc_error   <= 1'b0;
            unique case (r_state)
                ST_HUNT: begin
                    // Clearing on exit means a sync match needs 8 fresh HUNT bits.
                    if (w_sync_hit) begin
                        r_state   <= ST_DATA;
                        r_sync    <= '0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_sync <= w_sync_next[6:0];
                    end
                end
                ST_DATA: begin
                    r_pix_sh <= {r_pix_sh[PIXEL_W-2:0], i_apix_data};
                    if (r_bit_cnt == DATA_LAST) begin
                        r_state   <= ST_CRC;
                        r_bit_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_CRC: begin
                    r_rx_crc <= w_rx_crc_next[6:0];
                    if (r_bit_cnt == CRC_LAST) begin
                        r_state   <= ST_HUNT;
                        r_bit_cnt <= '0;
                        if (w_rx_crc_next == w_crc) begin
                            r_pixel_data  <= r_pix_sh;
                            r_pixel_valid <= 1'b1;
                            r_good_run    <= w_good_inc;
                            r_bad_run     <= '0;
                            if (w_good_inc == LOCK_N) begin
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_crc_error <= 1'b1;
                            r_err_count <= w_err_inc;
                            r_bad_run   <= w_bad_inc;
                            r_good_run  <= '0;
                            if (w_bad_inc == UNLOCK_N) begin
                                r_locked <= 1'b0;
                            end
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_HUNT;
                end
            endcase
        end
    end

    assign o_pixel_data  = r_pixel_data;
    assign o_pixel_valid = r_pixel_valid;
    assign o_crc_error   = r_crc_error;
    assign o_locked      = r_locked;
    assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_apix_receiver.sv
// Scoreboard bench for apix_receiver: frames push expected pulses,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_apix_receiver;
    import apix_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        apix_data;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        crc_error;
    logic        locked;
    logic [15:0] err_count;

    apix_receiver dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_apix_data   (apix_data),
        .o_pixel_data  (pixel_data),
        .o_pixel_valid (pixel_valid),
        .o_crc_error   (crc_error),
        .o_locked      (locked),
        .o_err_count   (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        int          at;
        logic [23:0] pix;
        bit          lock;
        logic [15:0] errc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    logic [23:0] m_pix  = '0;
    int          m_good = 0;
    int          m_bad  = 0;
    bit          m_lock = 1'b0;
    logic [15:0] m_err  = '0;

    // Byte-wise reference CRC-8, poly 0x07, init 0.
    function automatic logic [7:0] crc8(input logic [23:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 2; b >= 0; b--) begin
            c = c ^ p[b*8 +: 8];
            for (int i = 0; i < 8; i++) begin
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic put_bit(input logic b);
        apix_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put_bit(1'b0);
    endtask

    task automatic model_reset();
        m_pix  = '0;
        m_good = 0;
        m_bad  = 0;
        m_lock = 1'b0;
        m_err  = '0;
    endtask

    task automatic send_frame(input logic [23:0] pix, input logic [7:0] flip);
        logic [39:0] w;
        exp_t e;
        w = {SYNC_WORD_DEF, pix, crc8(pix) ^ flip};
        if (flip == 8'h00) begin
            m_pix  = pix;
            m_bad  = 0;
            if (m_good < 4) m_good++;
            if (m_good == 4) m_lock = 1'b1;
        end else begin
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
            m_good = 0;
            if (m_bad < 2) m_bad++;
            if (m_bad == 2) m_lock = 1'b0;
        end
        e.is_err = (flip != 8'h00);
        e.at     = cyc + 40;
        e.pix    = m_pix;
        e.lock   = m_lock;
        e.errc   = m_err;
        q.push_back(e);
        for (int i = 39; i >= 0; i--) put_bit(w[i]);
    endtask

    task automatic check_idle_state(input string tag);
        chk({tag, "_pixel"}, {8'h0, pixel_data}, 32'h0);
        chk({tag, "_valid"}, {31'h0, pixel_valid}, 32'h0);
        chk({tag, "_crcerr"}, {31'h0, crc_error}, 32'h0);
        chk({tag, "_locked"}, {31'h0, locked}, 32'h0);
        chk({tag, "_errcnt"}, {16'h0, err_count}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (!rst && (pixel_valid || crc_error)) begin
            exp_t e;
            chk("exclusive", {31'h0, pixel_valid & crc_error}, 32'h0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b at %0d want none",
                         pixel_valid, crc_error, cyc);
            end else begin
                e = q.pop_front();
                chk("kind_err", {31'h0, crc_error}, {31'h0, e.is_err});
                chk("cycle", cyc, e.at);
                chk("pixel", {8'h0, pixel_data}, {8'h0, e.pix});
                chk("locked", {31'h0, locked}, {31'h0, e.lock});
                chk("err_count", {16'h0, err_count}, {16'h0, e.errc});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] p;
        logic [23:0] ap;
        logic [39:0] w;
        rst = 1'b1;
        apix_data = 1'b0;
        put_bit(1'b0);
        put_bit(1'b1);
        rst = 1'b0;
        model_reset();
        check_idle_state("reset");
        idle(5);

        send_frame(24'hABCDEF, 8'h00);
        idle(2);
        send_frame(24'hABCDEF, 8'h01);
        idle(3);

        for (int i = 0; i < 4; i++) begin
            p = 24'($urandom);
            send_frame(p, 8'h00);
        end
        send_frame(24'h5A5A5A, 8'h80);
        send_frame(24'h0F0F0F, 8'h10);
        idle(4);

        // Sync plus 12 data bits, then reset while the line toggles.
        w = {SYNC_WORD_DEF, 24'hFEDCBA, crc8(24'hFEDCBA)};
        for (int i = 39; i >= 20; i--) put_bit(w[i]);
        rst = 1'b1;
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b1);
        rst = 1'b0;
        model_reset();
        check_idle_state("midrst");
        send_frame(24'h13579B, 8'h00);
        idle(3);

        ap = 24'h000100;
        while (crc8(ap) != 8'hA5) ap = ap + 24'd1;
        send_frame(ap, 8'h00);
        idle(3);
        send_frame(24'h2468AC, 8'h00);

        idle(45);
        chk("queue_empty", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
